goose_motion: RTL and testbench

Per-frame motion engine for the Goose Game. Integrates the goose's jump trajectory (height, airborne flag) and advances the world scroll position with a stepped speed ramp. Sits directly upstream of the game controller: it produces `in_air` and `scrolladdr`, and consumes `game_halt` and `game_reset`. Rendering and collision logic also read its outputs.

---
 rtl/goose_motion_if.sv | 32 +++
 rtl/goose_motion.sv | 168 ++++++++++++++++
 tb/tb_goose_motion.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/goose_motion_if.sv
// goose_motion_if -- frame-level control and motion outputs of the goose
// motion engine.
//   frame_tick   : one-cycle pulse per frame (start of vblank)
//   jump_button  : synchronised jump button, level
//   game_halt    : freeze motion and scroll while high
//   game_reset   : restart request (pulse or level)
//   goose_y      : goose height above ground, pixels
//   in_air       : high whenever the goose is not grounded
//   scrolladdr   : world scroll position, mod 2048
//   scroll_speed : current scroll increment per frame
// Modports: master drives the controls (game controller / bench),
//           slave is the motion engine.
interface goose_motion_if;
  logic        frame_tick;
  logic        jump_button;
  logic        game_halt;
  logic        game_reset;
  logic [6:0]  goose_y;
  logic        in_air;
  logic [10:0] scrolladdr;
  logic [3:0]  scroll_speed;

  modport master (
    output frame_tick, jump_button, game_halt, game_reset,
    input  goose_y, in_air, scrolladdr, scroll_speed
  );

  modport slave (
    input  frame_tick, jump_button, game_halt, game_reset,
    output goose_y, in_air, scrolladdr, scroll_speed
  );
endinterface

// File: rtl/goose_motion.sv
// goose_motion -- per-frame motion engine for the Goose Game.
// Integrates the jump trajectory (height + airborne flag) once per frame and
// advances the world scroll position with a stepped speed ramp.
// Ports:
//   clk   : pixel clock
//   rst_n : synchronous active-low reset
//   bus   : goose_motion_if.slave (frame_tick, jump_button, game_halt,
//           game_reset in; goose_y, in_air, scrolladdr, scroll_speed out)
// All outputs are registered; a tick sampled at edge N is visible in N+1.
module goose_motion #(
  parameter int unsigned JUMP_VEL          = 12,
  parameter int unsigned GRAVITY           = 1,
  parameter int unsigned SPEED_INIT        = 2,
  parameter int unsigned SPEED_MAX         = 6,
  parameter int unsigned SPEED_STEP_FRAMES = 600
) (
  input  logic          clk,
  input  logic          rst_n,
  goose_motion_if.slave bus
);

  localparam logic [3:0]  JUMP_VEL_L   = 4'(JUMP_VEL);
  localparam logic [3:0]  GRAVITY_L    = 4'(GRAVITY);
  localparam logic [3:0]  SPEED_INIT_L = 4'(SPEED_INIT);
  localparam logic [3:0]  SPEED_MAX_L  = 4'(SPEED_MAX);
  localparam logic [15:0] STEP_LAST    = 16'(SPEED_STEP_FRAMES - 1);

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    ASCEND   = 2'd1,
    DESCEND  = 2'd2
  } jump_state_e;

  jump_state_e state_q, state_d;
  logic [6:0]  y_q, y_d;
  logic [3:0]  vel_q, vel_d;
  logic [10:0] scroll_q, scroll_d;
  logic [3:0]  speed_q, speed_d;
  logic [15:0] ctr_q, ctr_d;
  logic        pending_q, pending_d;
  logic        in_air_q;
  logic        jump_q;

  logic        jump_rise;
  logic        launch;
  logic        tick_ok;
  logic [4:0]  fall_v;

  // NOTE: jump_q carries no reset on purpose: it only mirrors the button, so
  // tracking it through any reset keeps a button held across reset from
  // looking like a fresh press.
  always_ff @(posedge clk) begin
    jump_q <= bus.jump_button;
  end

  // NOTE: every state register uses non-blocking assignment so all flops
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= GROUNDED;
      y_q       <= '0;
      vel_q     <= '0;
      scroll_q  <= '0;
      speed_q   <= SPEED_INIT_L;
      ctr_q     <= '0;
      pending_q <= 1'b0;
      in_air_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      vel_q     <= vel_d;
      scroll_q  <= scroll_d;
      speed_q   <= speed_d;
      ctr_q     <= ctr_d;
      pending_q <= pending_d;
      in_air_q  <= (state_d != GROUNDED);
    end
  end

  assign jump_rise = bus.jump_button & ~jump_q;
  assign launch    = pending_q | jump_rise;
  assign tick_ok   = bus.frame_tick & ~bus.game_halt;
  // Falling speed for this tick; one bit wider so it cannot wrap.
  assign fall_v    = {1'b0, vel_q} + {1'b0, GRAVITY_L};

  // NOTE: every output of this block gets its hold value first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    vel_d     = vel_q;
    scroll_d  = scroll_q;
    speed_d   = speed_q;
    ctr_d     = ctr_q;
    pending_d = pending_q;

    // A press is remembered until the next frame; halt discards it so a
    // press made while frozen never queues a jump.
    if (bus.game_halt || bus.frame_tick) begin
      pending_d = 1'b0;
    end else if (jump_rise) begin
      pending_d = 1'b1;
    end

    if (tick_ok) begin
      unique case (state_q)
        GROUNDED: begin
          if (launch) begin
            state_d = ASCEND;
            vel_d   = JUMP_VEL_L;
          end
        end
        ASCEND: begin
          y_d = y_q + {3'b000, vel_q};
          if (vel_q <= GRAVITY_L) begin
            state_d = DESCEND;
            vel_d   = '0;
          end else begin
            vel_d = vel_q - GRAVITY_L;
          end
        end
        DESCEND: begin
          if (y_q <= {2'b00, fall_v}) begin
            state_d = GROUNDED;
            y_d     = '0;
            vel_d   = '0;
          end else begin
            y_d   = y_q - {2'b00, fall_v};
            vel_d = fall_v[3:0];
          end
        end
        default: begin
          state_d = GROUNDED;
          y_d     = '0;
          vel_d   = '0;
        end
      endcase

      scroll_d = scroll_q + {7'd0, speed_q};

      if (ctr_q == STEP_LAST) begin
        ctr_d = '0;
        if (speed_q < SPEED_MAX_L) begin
          speed_d = speed_q + 4'd1;
        end
      end else begin
        ctr_d = ctr_q + 16'd1;
      end
    end

    // Restart request overrides both the tick and halt.
    if (bus.game_reset) begin
      state_d   = GROUNDED;
      y_d       = '0;
      vel_d     = '0;
      scroll_d  = '0;
      speed_d   = SPEED_INIT_L;
      ctr_d     = '0;
      pending_d = 1'b0;
    end
  end

  assign bus.goose_y      = y_q;
  assign bus.in_air       = in_air_q;
  assign bus.scrolladdr   = scroll_q;
  assign bus.scroll_speed = speed_q;

endmodule

// File: tb/tb_goose_motion.sv
// tb_goose_motion -- scoreboard bench for goose_motion.
// Stimulus pushes the expected outputs for an upcoming update event (reset
// cycle, frame tick or game_reset) into a queue; an independent monitor counts
// update events and compares the outputs on the following falling edge.
module tb_goose_motion;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  goose_motion_if bus ();

  goose_motion dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          ev;
    string       name;
    logic [6:0]  y;
    logic        air;
    logic [10:0] scroll;
    logic [3:0]  speed;
  } exp_t;

  exp_t sb_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   issue_cnt = 0;
  int   ev_cnt    = 0;

  // Hand-computed 12/1 trajectory: height after each tick, launch tick first.
  int traj [25] = '{0, 12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78,
                    77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};

  // Scroll/speed reference for the long runs (speed steps every 600 ticks).
  logic [10:0] m_scroll;
  logic [3:0]  m_speed;
  int          m_ctr;

  // ---------------------------------------------------------------- monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst_n || bus.frame_tick || bus.game_reset) begin
        ev_cnt++;
        @(negedge clk);
        while (sb_q.size() != 0 && sb_q[0].ev == ev_cnt) begin
          e = sb_q.pop_front();
          checks++;
          if (bus.goose_y !== e.y || bus.in_air !== e.air ||
              bus.scrolladdr !== e.scroll || bus.scroll_speed !== e.speed) begin
            errors++;
            $display("FAIL %s: got y=%0d air=%0b scroll=%0d speed=%0d, expected y=%0d air=%0b scroll=%0d speed=%0d",
                     e.name, bus.goose_y, bus.in_air, bus.scrolladdr, bus.scroll_speed,
                     e.y, e.air, e.scroll, e.speed);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic push(input int ev, input string name, input logic [6:0] y,
                      input logic air, input logic [10:0] sc, input logic [3:0] sp);
    exp_t e;
    e.ev = ev; e.name = name; e.y = y; e.air = air; e.scroll = sc; e.speed = sp;
    sb_q.push_back(e);
  endtask

  task automatic model_step();
    m_scroll = m_scroll + 11'(m_speed);
    if (m_ctr == 599) begin
      m_ctr = 0;
      if (m_speed < 4'd6) m_speed = m_speed + 4'd1;
    end else begin
      m_ctr = m_ctr + 1;
    end
  endtask

  task automatic pulse_tick(input bit with_rise);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    if (with_rise) bus.jump_button = 1'b1;
    issue_cnt++;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Tick whose scroll/speed expectation comes from the reference.
  task automatic do_tick(input bit chk, input string name, input logic [6:0] y,
                         input logic air, input bit with_rise);
    if (!bus.game_halt) model_step();
    if (chk) push(issue_cnt + 1, name, y, air, m_scroll, m_speed);
    pulse_tick(with_rise);
  endtask

  // Tick with fully hand-written expectations.
  task automatic do_tick_lit(input string name, input logic [6:0] y, input logic air,
                             input logic [10:0] sc, input logic [3:0] sp);
    if (!bus.game_halt) model_step();
    push(issue_cnt + 1, name, y, air, sc, sp);
    pulse_tick(1'b0);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b0, "", 7'd0, 1'b0, 1'b0);
  endtask

  task automatic game_reset_pulse(input string name, input bit with_tick);
    m_scroll = '0; m_speed = 4'd2; m_ctr = 0;
    push(issue_cnt + 1, name, 7'd0, 1'b0, 11'd0, 4'd2);
    @(negedge clk);
    bus.game_reset = 1'b1;
    bus.frame_tick = with_tick;
    issue_cnt++;
    @(negedge clk);
    bus.game_reset = 1'b0;
    bus.frame_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.frame_tick  = 1'b0;
    bus.jump_button = 1'b0;
    bus.game_halt   = 1'b0;
    bus.game_reset  = 1'b0;
    m_scroll = '0; m_speed = 4'd2; m_ctr = 0;

    // Power-on reset: three reset cycles, check after the last.
    push(3, "por", 7'd0, 1'b0, 11'd0, 4'd2);
    repeat (3) @(negedge clk);
    issue_cnt = 3;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Idle scrolling: 10 ticks at speed 2.
    for (int i = 1; i <= 9; i++) do_tick(1'b1, "scroll_idle", 7'd0, 1'b0, 1'b0);
    do_tick_lit("scroll_10", 7'd0, 1'b0, 11'd20, 4'd2);

    // Full jump from a mid-frame press; a second press in flight is ignored.
    bus.jump_button = 1'b1;
    for (int i = 0; i < 25; i++) begin
      do_tick(1'b1, $sformatf("jump_t%0d", i + 1), 7'(traj[i]), (i < 24), 1'b0);
      if (i == 2)  bus.jump_button = 1'b0;
      if (i == 3)  bus.jump_button = 1'b1;
      if (i == 10) bus.jump_button = 1'b0;
    end
    do_tick(1'b1, "no_relaunch", 7'd0, 1'b0, 1'b0);

    // Halt while airborne at height 50, with a press during the halt.
    bus.jump_button = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_tick(1'b1, $sformatf("halt_pre_t%0d", i + 1), 7'(traj[i]), 1'b1, 1'b0);
      if (i == 0) bus.jump_button = 1'b0;
    end
    bus.game_halt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      do_tick(1'b1, "halt_freeze", 7'd50, 1'b1, 1'b0);
      if (k == 1) bus.jump_button = 1'b1;
      if (k == 3) bus.jump_button = 1'b0;
    end
    bus.game_halt = 1'b0;
    for (int i = 6; i < 25; i++)
      do_tick(1'b1, $sformatf("halt_resume_t%0d", i + 1), 7'(traj[i]), (i < 24), 1'b0);
    do_tick(1'b1, "halt_land_idle", 7'd0, 1'b0, 1'b0);

    // Press while grounded and halted must not launch after halt drops.
    bus.game_halt = 1'b1;
    @(negedge clk) bus.jump_button = 1'b1;
    repeat (2) @(negedge clk);
    bus.game_halt = 1'b0;
    do_tick(1'b1, "halt_rise_dropped", 7'd0, 1'b0, 1'b0);
    bus.jump_button = 1'b0;

    // Restart, then scroll wrap at speed 3: 2046 + 3 -> 1.
    game_reset_pulse("greset", 1'b0);
    run_ticks(881);
    do_tick_lit("wrap_2046", 7'd0, 1'b0, 11'd2046, 4'd3);
    do_tick_lit("wrap_1", 7'd0, 1'b0, 11'd1, 4'd3);
    run_ticks(916);
    do_tick_lit("speed5", 7'd0, 1'b0, 11'd1304, 4'd5);

    // Press on the same edge as a tick launches; button then held.
    do_tick(1'b1, "rise_with_tick", 7'd0, 1'b1, 1'b1);
    do_tick(1'b1, "air_s5_t2", 7'd12, 1'b1, 1'b0);
    do_tick(1'b1, "air_s5_t3", 7'd23, 1'b1, 1'b0);
    do_tick(1'b1, "air_s5_t4", 7'd33, 1'b1, 1'b0);
    game_reset_pulse("reset_vs_tick", 1'b1);
    do_tick_lit("held_no_launch", 7'd0, 1'b0, 11'd2, 4'd2);
    bus.jump_button = 1'b0;

    // Speed ramp: boundary at 600, ceiling at 6.
    game_reset_pulse("greset2", 1'b0);
    run_ticks(598);
    do_tick_lit("ramp_599", 7'd0, 1'b0, 11'd1198, 4'd2);
    do_tick_lit("ramp_600", 7'd0, 1'b0, 11'd1200, 4'd3);
    run_ticks(1799);
    do_tick_lit("ramp_2400", 7'd0, 1'b0, 11'd208, 4'd6);
    run_ticks(1199);
    do_tick_lit("ramp_3600", 7'd0, 1'b0, 11'd1264, 4'd6);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries never compared, expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
